// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : ID-stage load-use / branch-register hazard stall and flush control.
//            Optional stall counters are enabled by defining HAZ_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW        = 4,
    parameter int LOAD_LAT      = 1,
    parameter int ZERO_REG_HARD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_brreg,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              ex_memread,
    input  logic              mem_memread,
    output logic              stall,
    output logic              flush
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       stall_events
`endif
);

    localparam int c_cnt_w = $clog2(LOAD_LAT + 2);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_lat    = c_cnt_w'(LOAD_LAT);
    localparam logic [c_cnt_w-1:0] c_lat_p1 = c_cnt_w'(LOAD_LAT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cnt_w-1:0]   w_n;
    logic                 w_stall_raw;
    logic                 w_ex_rs;
    logic                 w_ex_rt;
    logic                 w_mem_rs;

    function automatic logic producer(input logic we, input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return we && (rd == r) && ((ZERO_REG_HARD == 0) || (r != '0));
    endfunction

    assign w_ex_rs  = producer(ex_regwrite, ex_rd, id_rs);
    assign w_ex_rt  = producer(ex_regwrite, ex_rd, id_rt) && id_uses_rt;
    assign w_mem_rs = producer(mem_regwrite, mem_rd, id_rs);

    // N is the longest of every applicable candidate stall length.
    always_comb begin
        w_n = '0;
        if (id_valid) begin
            if (ex_memread && (w_ex_rs || w_ex_rt) && (c_lat > w_n))
                w_n = c_lat;
            if (id_is_brreg) begin
                if (w_ex_rs && !ex_memread && (c_one > w_n))
                    w_n = c_one;
                if (w_ex_rs && ex_memread && (c_lat_p1 > w_n))
                    w_n = c_lat_p1;
                if (w_mem_rs && mem_memread && (c_lat > w_n))
                    w_n = c_lat;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_raw = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall_raw = (w_n != '0);
                if (w_n > c_one) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = w_n - c_one;
                end
            end
            ST_HOLD: begin
                w_stall_raw = 1'b1;
                if (r_cnt == c_one) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs drop with reset immediately, not at the next edge.
    assign stall = rst_n & w_stall_raw;
    assign flush = rst_n & br_taken & ~w_stall_raw;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_stall_events;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            if (w_stall_raw && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if ((r_state == ST_IDLE) && w_stall_raw && (r_stall_events != 16'hFFFF))
                r_stall_events <= r_stall_events + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign stall_events = r_stall_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench over five parameter sets of pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int NI = 5;
    localparam int LAT_T [NI] = '{1, 2, 3, 4, 1};
    localparam int ZRH_T [NI] = '{1, 1, 1, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, id_is_brreg, br_taken;
    logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       ex_regwrite, mem_regwrite, ex_memread, mem_memread;

    logic        stall_v [NI];
    logic        flush_v [NI];
    logic [15:0] cyc_v   [NI];
    logic [15:0] evt_v   [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .REG_AW(4), .LOAD_LAT(LAT_T[g]), .ZERO_REG_HARD(ZRH_T[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
            .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_brreg(id_is_brreg),
            .br_taken(br_taken), .ex_rd(ex_rd), .mem_rd(mem_rd),
            .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
            .ex_memread(ex_memread), .mem_memread(mem_memread),
            .stall(stall_v[g]), .flush(flush_v[g])
`ifdef HAZ_STALL_CNT_EN
            , .stall_cycles(cyc_v[g]), .stall_events(evt_v[g])
`endif
        );
`ifndef HAZ_STALL_CNT_EN
        assign cyc_v[g] = 16'd0;
        assign evt_v[g] = 16'd0;
`endif
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: hazard length straight from the producer/consumer rules.
    function automatic int calc_n(input int lat, input int zrh);
        int  n;
        bit  ex_rs, ex_rt, mem_rs;
        n = 0;
        if (!id_valid) return 0;
        ex_rs  = ex_regwrite && ex_rd == id_rs && (zrh == 0 || id_rs != 0);
        ex_rt  = ex_regwrite && ex_rd == id_rt && (zrh == 0 || id_rt != 0) && id_uses_rt;
        mem_rs = mem_regwrite && mem_rd == id_rs && (zrh == 0 || id_rs != 0);
        if (ex_memread && (ex_rs || ex_rt) && lat > n) n = lat;
        if (id_is_brreg) begin
            if (ex_rs && !ex_memread && 1 > n) n = 1;
            if (ex_rs && ex_memread && lat + 1 > n) n = lat + 1;
            if (mem_rs && mem_memread && lat > n) n = lat;
        end
        return n;
    endfunction

    int rem   [NI];
    int m_cyc [NI];
    int m_evt [NI];

    function automatic bit exp_stall(input int i);
        return rst_n && (rem[i] > 0 || calc_n(LAT_T[i], ZRH_T[i]) > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                rem[i] = 0; m_cyc[i] = 0; m_evt[i] = 0;
            end else begin
                if (exp_stall(i) && m_cyc[i] < 65535) m_cyc[i]++;
                if (rem[i] > 0) begin
                    rem[i]--;
                end else if (calc_n(LAT_T[i], ZRH_T[i]) > 0) begin
                    rem[i] = calc_n(LAT_T[i], ZRH_T[i]) - 1;
                    if (m_evt[i] < 65535) m_evt[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_stall[%0d]", i), int'(stall_v[i]), int'(exp_stall(i)));
            chk($sformatf("model_flush[%0d]", i), int'(flush_v[i]),
                int'(rst_n && br_taken && !exp_stall(i)));
`ifdef HAZ_STALL_CNT_EN
            chk($sformatf("model_cyc[%0d]", i), int'(cyc_v[i]), m_cyc[i]);
            chk($sformatf("model_evt[%0d]", i), int'(evt_v[i]), m_evt[i]);
`endif
        end
    end

    task automatic set_in(input bit v, input int rs, input int rt, input bit urt,
                          input bit brr, input bit brt, input int erd, input bit ewe,
                          input bit emr, input int mrd, input bit mwe, input bit mmr);
        id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_uses_rt = urt;
        id_is_brreg = brr; br_taken = brt; ex_rd = 4'(erd); ex_regwrite = ewe;
        ex_memread = emr; mem_rd = 4'(mrd); mem_regwrite = mwe; mem_memread = mmr;
    endtask

    // Inputs that can never produce a hazard but may still flush.
    task automatic set_junk();
        set_in(1'b0, $urandom_range(15), $urandom_range(15), 1'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(15), 1'($urandom), 1'($urandom),
               $urandom_range(15), 1'($urandom), 1'($urandom));
    endtask

    // Present one vector for a cycle, scramble inputs afterwards, and measure
    // each instance's contiguous stall run starting in the detection cycle.
    task automatic run_case(input string nm, input bit v, input int rs, input int rt,
                            input bit urt, input bit brr, input int erd, input bit ewe,
                            input bit emr, input int mrd, input bit mwe, input bit mmr,
                            input int e0, input int e1, input int e2, input int e3,
                            input int e4);
        int  len [NI];
        bit  alive [NI];
        int  exp [NI];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < NI; i++) begin len[i] = 0; alive[i] = 1'b1; end
        @(posedge clk); #1;
        set_in(v, rs, rt, urt, brr, 1'b0, erd, ewe, emr, mrd, mwe, mmr);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (alive[i] && stall_v[i]) len[i]++;
                else alive[i] = 1'b0;
            end
            @(posedge clk); #1;
            set_junk();
        end
        for (int i = 0; i < NI; i++)
            chk($sformatf("%s_len[%0d]", nm, i), len[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        #1;
        chk("reset_stall", int'(stall_v[0]), 0);
        chk("reset_flush", int'(flush_v[0]), 0);
`ifdef HAZ_STALL_CNT_EN
        chk("reset_cyc", int'(cyc_v[0]), 0);
        chk("reset_evt", int'(evt_v[0]), 0);
`endif
        //       name     v rs rt urt brr erd ewe emr mrd mwe mmr  lengths per instance
        run_case("lu_rs",  1, 3, 0, 0, 0,  3, 1, 1,  0, 0, 0,  1, 2, 3, 4, 1);
`ifdef HAZ_STALL_CNT_EN
        chk("lu_rs_evt0", int'(evt_v[0]), 1);
        chk("lu_rs_cyc0", int'(cyc_v[0]), 1);
`endif
        run_case("lu_rt",  1, 7, 5, 1, 0,  5, 1, 1,  0, 0, 0,  1, 2, 3, 4, 1);
        run_case("lu_nort",1, 7, 5, 0, 0,  5, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        run_case("br_exld",1, 2, 0, 0, 1,  2, 1, 1,  0, 0, 0,  2, 3, 4, 5, 2);
        run_case("br_exalu",1,2, 0, 0, 1,  2, 1, 0,  0, 0, 0,  1, 1, 1, 1, 1);
        run_case("br_memld",1,2, 0, 0, 1,  0, 0, 0,  2, 1, 1,  1, 2, 3, 4, 1);
        run_case("br_max", 1, 2, 0, 0, 1,  2, 1, 0,  2, 1, 1,  1, 2, 3, 4, 1);
        run_case("memld_nb",1,2, 0, 0, 0,  0, 0, 0,  2, 1, 1,  0, 0, 0, 0, 0);
        run_case("zero_reg",1,0, 0, 0, 0,  0, 1, 1,  0, 0, 0,  0, 0, 0, 0, 1);
        run_case("invalid",0, 3, 3, 1, 1,  3, 1, 1,  3, 1, 1,  0, 0, 0, 0, 0);
        run_case("no_we",  1, 3, 3, 1, 1,  3, 0, 1,  3, 0, 1,  0, 0, 0, 0, 0);

        // Taken branch, no hazard: flush.
        @(posedge clk); #1;
        set_in(1, 4, 6, 1, 1, 1, 9, 1, 1, 10, 1, 1);
        @(negedge clk);
        chk("br_flush", int'(flush_v[0]), 1);
        chk("br_flush_nostall", int'(stall_v[0]), 0);
        // Taken branch colliding with a hazard: stall wins.
        @(posedge clk); #1;
        set_in(1, 2, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("br_haz_flush[%0d]", i), int'(flush_v[i]), 0);
            chk($sformatf("br_haz_stall[%0d]", i), int'(stall_v[i]), 1);
        end
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) @(posedge clk);

        // Reset in the second stall cycle of a LOAD_LAT=4 load-use.
        #1 set_in(1, 3, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_pre_stall3", int'(stall_v[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall3", int'(stall_v[3]), 0);
`ifdef HAZ_STALL_CNT_EN
        chk("rst_mid_cyc3", int'(cyc_v[3]), 0);
        chk("rst_mid_evt3", int'(evt_v[3]), 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_after_stall3_%0d", c), int'(stall_v[3]), 0);
        end

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
